// File: rtl/shift_sequencer.sv
// shift_sequencer: runs ARM register-specified shifts (amount 0..255) as a
// sequence of barrel-shifter passes of at most 31 bits each, and derives the
// ARM shifter carry-out from the last pass.
//
// Also contains barrelshifter, the single-cycle 32-bit shifter with a 5-bit
// count that the sequencer drives one pass at a time.

// barrelshifter: combinational 32-bit shifter built as five log stages.
// Stage gi shifts by 2**gi when count bit gi is set.
// mode: 0 LSL, 1 LSR, 2 ASR, 3 ROR.
module barrelshifter (
    input  logic [31:0] data_i,
    input  logic [4:0]  count_i,
    input  logic [1:0]  mode_i,
    output logic [31:0] data_o
);

    // Shift by a fixed, non-zero distance in the selected mode
    function automatic logic [31:0] shift_fixed(input logic [31:0] d,
                                                input logic [1:0]  m,
                                                input int unsigned s);
        logic [31:0] r;
        case (m)
            2'd0:    r = d << s;
            2'd1:    r = d >> s;
            2'd2:    r = $signed(d) >>> s;
            default: r = (d >> s) | (d << (32 - s));
        endcase
        return r;
    endfunction

    logic [31:0] stage [0:5];

    assign stage[0] = data_i;

    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
        assign stage[gi+1] = count_i[gi]
                           ? shift_fixed(stage[gi], mode_i, 32'd1 << gi)
                           : stage[gi];
    end

    assign data_o = stage[5];

endmodule

module shift_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_amount,
    input  logic [31:0] req_data,
    input  logic        req_carry_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_carry,
    output logic        busy
);

    localparam logic [1:0] OP_LSL = 2'd0;
    localparam logic [1:0] OP_LSR = 2'd1;
    localparam logic [1:0] OP_ASR = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    // The working register doubles as the response data: it is only
    // overwritten on accept and during passes, so it holds in DONE and IDLE.
    logic [31:0] work_q, work_d;
    logic [7:0]  rem_q, rem_d;
    logic        carry_q, carry_d;

    logic [4:0]  chunk;
    logic [4:0]  lsl_idx;
    logic [4:0]  lsr_idx;
    logic        pass_carry;
    logic [31:0] bs_out;

    // Pass size: whatever is left, capped at the shifter's 31-bit limit
    always_comb begin
        chunk = (rem_q > 8'd31) ? 5'd31 : rem_q[4:0];
    end

    barrelshifter u_bs (
        .data_i  (work_q),
        .count_i (chunk),
        .mode_i  (op_q),
        .data_o  (bs_out)
    );

    // Carry-out of the current pass, taken from the value before shifting.
    // chunk is never 0 in SHIFT, so both indices stay in 1..31 / 0..30.
    always_comb begin
        lsl_idx    = 5'(6'd32 - {1'b0, chunk});
        lsr_idx    = chunk - 5'd1;
        pass_carry = 1'b0;
        case (op_q)
            OP_LSL:  pass_carry = work_q[lsl_idx];
            default: pass_carry = work_q[lsr_idx];
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LSL;
            work_q  <= 32'd0;
            rem_q   <= 8'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
        end
    end

    // Next-state: accept in IDLE, one pass per cycle in SHIFT, hold in DONE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        work_d  = work_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    work_d  = req_data;
                    carry_d = req_carry_in;
                    rem_d   = req_amount;
                    if (req_amount == 8'd0) begin
                        state_d = ST_DONE;
                    end else if (req_op == OP_ROR) begin
                        // Rotation by a multiple of 32 leaves data unchanged
                        // but still reports bit 31 as carry.
                        if (req_amount[4:0] == 5'd0) begin
                            carry_d = req_data[31];
                            rem_d   = 8'd0;
                            state_d = ST_DONE;
                        end else begin
                            rem_d   = {3'b000, req_amount[4:0]};
                            state_d = ST_SHIFT;
                        end
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = bs_out;
                carry_d = pass_carry;
                rem_d   = rem_q - {3'b000, chunk};
                if (rem_q == {3'b000, chunk}) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = work_q;
    assign rsp_carry = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: hand-computed shift results, carries
// and pass latencies, plus backpressure and mid-operation reset.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_amount;
    logic [31:0] req_data;
    logic        req_carry_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_carry;
    logic        busy;

    int errors = 0;
    int checks = 0;

    shift_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_amount   (req_amount),
        .req_data     (req_data),
        .req_carry_in (req_carry_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request and hold it across exactly one rising edge (E0)
    task automatic send_req(input logic [1:0] op, input logic [7:0] amt,
                            input logic [31:0] data, input logic cin);
        @(negedge clk);
        req_op       = op;
        req_amount   = amt;
        req_data     = data;
        req_carry_in = cin;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges after E0 until rsp_valid; bounded at 20
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // Complete the response handshake
    task automatic take_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rsp_data !== 32'h0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_outputs got=%h/%b exp=00000000/0", rsp_data, rsp_carry); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: req_ready=%b rsp_valid=%b busy=%b", req_ready, rsp_valid, busy);
    endtask

    task automatic test_lsl_one();
        int lat;
        send_req(2'd0, 8'd1, 32'h80000001, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsl1_busy got=%b exp=1", busy); end
        wait_rsp(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lsl1_latency got=%0d exp=1", lat); end
        checks++; if (rsp_data !== 32'h00000002) begin errors++; $display("FAIL lsl1_data got=%h exp=00000002", rsp_data); end
        checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL lsl1_carry got=%b exp=1", rsp_carry); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL lsl1_ready_in_done got=%b exp=0", req_ready); end
        take_rsp();
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL lsl1_back_idle got=%b/%b exp=1/0", req_ready, rsp_valid); end
        $display("LSL 80000001 by 1: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
    endtask

    task automatic test_lsr_40();
        int lat;
        send_req(2'd1, 8'd40, 32'hfffffffe, 1'b1);
        @(posedge clk);
        #1;
        checks++; if (rsp_data !== 32'h00000001) begin errors++; $display("FAIL lsr40_intermediate got=%h exp=00000001", rsp_data); end
        wait_rsp(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL lsr40_latency got=%0d exp=1 more", lat); end
        checks++; if (rsp_data !== 32'h0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL lsr40_result got=%h/%b exp=00000000/0", rsp_data, rsp_carry); end
        take_rsp();
        $display("LSR fffffffe by 40: data=%h carry=%b", rsp_data, rsp_carry);
    endtask

    task automatic test_lsl_32();
        int lat;
        send_req(2'd0, 8'd32, 32'h00000001, 1'b0);
        wait_rsp(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lsl32_latency got=%0d exp=2", lat); end
        checks++; if (rsp_data !== 32'h0 || rsp_carry !== 1'b1) begin errors++; $display("FAIL lsl32_result got=%h/%b exp=00000000/1", rsp_data, rsp_carry); end
        take_rsp();
        $display("LSL 00000001 by 32: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
    endtask

    task automatic test_asr_255();
        int lat;
        send_req(2'd2, 8'd255, 32'h80000000, 1'b0);
        wait_rsp(lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL asr255_latency got=%0d exp=9", lat); end
        checks++; if (rsp_data !== 32'hffffffff || rsp_carry !== 1'b1) begin errors++; $display("FAIL asr255_result got=%h/%b exp=ffffffff/1", rsp_data, rsp_carry); end
        take_rsp();
        $display("ASR 80000000 by 255: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
    endtask

    task automatic test_ror();
        int lat;
        send_req(2'd3, 8'd36, 32'h0000000f, 1'b0);
        wait_rsp(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ror36_latency got=%0d exp=1", lat); end
        checks++; if (rsp_data !== 32'hf0000000 || rsp_carry !== 1'b1) begin errors++; $display("FAIL ror36_result got=%h/%b exp=f0000000/1", rsp_data, rsp_carry); end
        take_rsp();
        $display("ROR 0000000f by 36: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
        send_req(2'd3, 8'd32, 32'h80000000, 1'b0);
        wait_rsp(lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL ror32_latency got=%0d exp=0", lat); end
        checks++; if (rsp_data !== 32'h80000000 || rsp_carry !== 1'b1) begin errors++; $display("FAIL ror32_result got=%h/%b exp=80000000/1", rsp_data, rsp_carry); end
        take_rsp();
        $display("ROR 80000000 by 32: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
    endtask

    task automatic test_amount_zero();
        int lat;
        send_req(2'd1, 8'd0, 32'h12345678, 1'b1);
        wait_rsp(lat);
        checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got=%0d exp=0", lat); end
        checks++; if (rsp_data !== 32'h12345678 || rsp_carry !== 1'b1) begin errors++; $display("FAIL zero_result got=%h/%b exp=12345678/1", rsp_data, rsp_carry); end
        take_rsp();
        checks++; if (rsp_data !== 32'h12345678 || rsp_carry !== 1'b1) begin errors++; $display("FAIL zero_hold_in_idle got=%h/%b exp=12345678/1", rsp_data, rsp_carry); end
        $display("amount 0 on 12345678: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        send_req(2'd2, 8'd33, 32'h7fffffff, 1'b1);
        wait_rsp(lat);
        checks++; if (lat !== 2 || rsp_data !== 32'h0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL asr33_result got=%h/%b lat=%0d exp=00000000/0 lat=2", rsp_data, rsp_carry, lat); end
        take_rsp();
        $display("ASR 7fffffff by 33: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
        send_req(2'd1, 8'd32, 32'h80000000, 1'b0);
        wait_rsp(lat);
        checks++; if (lat !== 2 || rsp_data !== 32'h0 || rsp_carry !== 1'b1) begin errors++; $display("FAIL lsr32_result got=%h/%b lat=%0d exp=00000000/1 lat=2", rsp_data, rsp_carry, lat); end
        take_rsp();
        $display("LSR 80000000 by 32: data=%h carry=%b lat=%0d", rsp_data, rsp_carry, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        send_req(2'd0, 8'd4, 32'h00000001, 1'b1);
        wait_rsp(lat);
        checks++; if (rsp_data !== 32'h00000010 || rsp_carry !== 1'b0) begin errors++; $display("FAIL bp_first_result got=%h/%b exp=00000010/0", rsp_data, rsp_carry); end
        // Pending request while the response is stalled
        @(negedge clk);
        req_op       = 2'd1;
        req_amount   = 8'd4;
        req_data     = 32'h000000f0;
        req_carry_in = 1'b1;
        req_valid    = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1 ||
                rsp_data !== 32'h00000010 || rsp_carry !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_stall_stable bad_cycles=%0d exp=0 data=%h carry=%b", bad, rsp_data, rsp_carry); end
        take_rsp();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_visit got=%b exp=1", req_ready); end
        // Held request is accepted on the following edge
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_pending_accept got=%b exp=1", busy); end
        wait_rsp(lat);
        checks++; if (lat !== 1 || rsp_data !== 32'h0000000f || rsp_carry !== 1'b0) begin errors++; $display("FAIL bp_second_result got=%h/%b lat=%0d exp=0000000f/0 lat=1", rsp_data, rsp_carry, lat); end
        take_rsp();
        $display("backpressure: stalled 5 cycles, pending LSR done data=%h carry=%b", rsp_data, rsp_carry);
    endtask

    task automatic test_reset_midop();
        int seen;
        send_req(2'd2, 8'd255, 32'h80000000, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got ready=%b valid=%b busy=%b exp=1/0/0", req_ready, rsp_valid, busy); end
        checks++; if (rsp_data !== 32'h0 || rsp_carry !== 1'b0) begin errors++; $display("FAIL midrst_outputs got=%h/%b exp=00000000/0", rsp_data, rsp_carry); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_response got=%0d exp=0", seen); end
        $display("reset mid ASR: ready=%b valid=%b data=%h", req_ready, rsp_valid, rsp_data);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_op       = 2'd0;
        req_amount   = 8'd0;
        req_data     = 32'h0;
        req_carry_in = 1'b0;
        rsp_ready    = 1'b0;
        test_reset();
        test_lsl_one();
        test_lsr_40();
        test_lsl_32();
        test_asr_255();
        test_ror();
        test_amount_zero();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that executes ARM register-specified shifts (amount 0..255) on the single-cycle 32-bit barrelshifter, which accepts at most a 5-bit count. It accepts one request at a time over a valid/ready handshake. It splits the amount into passes of at most 31, sequences the barrelshifter pass by pass, and derives the ARM shifter carry-out. It sits between decode/operand-fetch and the ALU operand-2 path.

## Interface
- No parameters; datapath fixed at 32 bits, amount at 8 bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_op  in  2  0 LSL, 1 LSR, 2 ASR, 3 ROR (same encoding as barrelshifter mode)
- req_amount  in  8  shift amount, low byte of Rs
- req_data  in  32  operand
- req_carry_in  in  1  current CPSR C
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  shifted result
- rsp_carry  out  1  shifter carry-out
- busy  out  1  high in SHIFT or DONE

## Operation
- Internal barrelshifter instance; its input is the working register, its count is the pass chunk, and its mode is the latched op.
- FSM states:
  - IDLE: req_ready=1.
  - SHIFT: one pass per cycle.
  - DONE: rsp_valid=1.
- Accept when req_valid && req_ready.
  - At the accepting edge E0, latch op, data, and remaining = req_amount.
  - Latch carry = req_carry_in.
- Zero-pass cases go IDLE->DONE at E0:
  - amount==0, any op: rsp_data=req_data, rsp_carry=req_carry_in.
  - ROR with amount!=0 and amount[4:0]==0: rsp_data=req_data, rsp_carry=req_data[31].
- ROR with amount[4:0]!=0 runs exactly one pass with count=amount[4:0].
- LSL/LSR/ASR with amount!=0 run p=ceil(amount/31) passes.
  - Each pass uses chunk k=min(remaining,31).
  - The working register takes the barrelshifter output, and remaining -= k.
- Per-pass carry, taken from the working value before the pass:
  - LSL: bit[32-k]
  - LSR/ASR: bit[k-1]
  - ROR: bit[k-1] (equals result bit 31)
- Final carry is the carry from the last pass. The chained passes therefore reproduce ARM semantics:
  - LSL/LSR by 32 gives C = bit0/bit31.
  - LSL/LSR by more than 32 gives result 0, C 0.
  - ASR by 32 or more gives all sign bits, C = sign.
- SHIFT->DONE on the edge where remaining becomes 0.
- DONE->IDLE on an edge with rsp_ready=1.
  - rsp_data and rsp_carry are held stable while in DONE.
  - They keep their last value in IDLE.
- Requests arriving while req_ready=0 are not accepted. The requester must hold them.
- remaining is 8-bit and never underflows, because k ≤ remaining.

## Timing
- Reset (async, immediate) values:
  - state IDLE
  - req_ready=1, rsp_valid=0, busy=0
  - rsp_data=0, rsp_carry=0
  - working register and remaining = 0
- Reset mid-operation aborts the request. No response is produced for it.
- Latency:
  - rsp_valid rises after edge Ep, i.e. p cycles after the accepting edge.
  - Zero-pass requests: rsp_valid rises after E0.
  - Maximum p=9 (amount 255).
- Throughput: one request per p+2 cycles at best. There is no accept in the same cycle as a rsp handshake; IDLE is always visited for at least one cycle.
- req_ready and rsp_valid are mutually exclusive. busy = !req_ready.

## Test plan
- LSL, data 0x80000001, amount 1, C_in 0 -> one pass; rsp after E1: data 0x00000002, carry 1.
- LSR, data 0xfffffffe, amount 40 -> passes 31 and 9.
  - Intermediate 0x00000001.
  - rsp after E2: data 0x00000000, carry 0.
- LSL, data 0x00000001, amount 32 -> passes 31 and 1; rsp: data 0x00000000, carry 1.
- ASR, data 0x80000000, amount 255 -> 9 passes; rsp after E9: data 0xffffffff, carry 1.
- ROR 0x0000000f by 36 -> 0xf0000000, carry 1, one pass.
- ROR 0x80000000 by 32 -> zero-pass: data 0x80000000, carry 1.
- Amount 0, data 0x12345678, C_in 1 -> rsp after E0: data 0x12345678, carry 1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 5 cycles: rsp_data and rsp_carry stay stable, req_ready stays 0, and a pending req_valid is not accepted.
  - Assert rst during pass 3 of an ASR by 255: immediate IDLE, rsp_valid 0, outputs 0, and no response after rst release.
